// File: rtl/pcie_framing_pkg.sv
// Shared Gen3 framing definitions: STP token layout, legal length bounds and
// the receive FSM state encoding.
package pcie_framing_pkg;

    localparam logic [3:0] STP_MARKER  = 4'hF;
    localparam int         MIN_LEN_DEF = 5;
    localparam int         MAX_LEN_DEF = 1031;

    typedef struct packed {
        logic [10:0] len;
        logic        fp;
        logic [3:0]  fcrc;
        logic [11:0] seq;
    } stp_token_t;

    typedef enum logic {
        ST_IDLE,
        ST_PAYLOAD
    } rx_state_e;

    // Byte0 is the first symbol on the wire; the marker nibble is checked by the caller.
    function automatic stp_token_t stp_unpack(input logic [31:0] dw);
        stp_token_t t;
        t.len  = {dw[14:8], dw[7:4]};
        t.fp   = dw[15];
        t.fcrc = dw[19:16];
        t.seq  = {dw[23:20], dw[31:24]};
        return t;
    endfunction

endpackage

// File: rtl/stp_framing_rx_if.sv
// Symbol-stream input and delimited TLP output of the Gen3 framing receiver.
interface stp_framing_rx_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      rx_data;
    logic             rx_valid;
    logic             rx_flush;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_sop;
    logic             out_eop;
    logic [11:0]      out_seq;
    logic             out_abort;
    logic             err_fcrc;
    logic             err_fp;
    logic             err_len;
    logic             err_unexp;
    logic [CNT_W-1:0] good_cnt;

    modport master (
        output rx_data, rx_valid, rx_flush,
        input  out_data, out_valid, out_sop, out_eop, out_seq, out_abort,
        input  err_fcrc, err_fp, err_len, err_unexp, good_cnt
    );

    modport slave (
        input  rx_data, rx_valid, rx_flush,
        output out_data, out_valid, out_sop, out_eop, out_seq, out_abort,
        output err_fcrc, err_fp, err_len, err_unexp, good_cnt
    );
endinterface

// File: rtl/stp_fcrc_calc.sv
// Frame CRC and frame parity over the 11-bit STP Length; shared with the TX token generator.
module stp_fcrc_calc (
    input  logic [10:0] len_i,
    output logic [3:0]  fcrc_o,
    output logic        fp_o
);
    assign fcrc_o[0] = len_i[10] ^ len_i[7] ^ len_i[6] ^ len_i[4] ^ len_i[2] ^ len_i[1] ^ len_i[0];
    assign fcrc_o[1] = len_i[10] ^ len_i[9] ^ len_i[7] ^ len_i[5] ^ len_i[4] ^ len_i[3] ^ len_i[2];
    assign fcrc_o[2] = len_i[9]  ^ len_i[8] ^ len_i[6] ^ len_i[4] ^ len_i[3] ^ len_i[2] ^ len_i[1];
    assign fcrc_o[3] = len_i[8]  ^ len_i[7] ^ len_i[5] ^ len_i[3] ^ len_i[2] ^ len_i[1] ^ len_i[0];
    assign fp_o      = len_i[10] ^ len_i[9] ^ len_i[8] ^ len_i[6] ^ len_i[5] ^ len_i[2] ^ len_i[0];
endmodule

// File: rtl/stp_framing_rx.sv
// Gen3 receive framing: validates STP tokens, then delimits and forwards the
// TLP dwords that follow with sop/eop and the latched sequence number.
module stp_framing_rx
    import pcie_framing_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    stp_framing_rx_if.slave bus
);
    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    stp_token_t tok;
    logic [3:0] fcrc_calc;
    logic       fp_calc;
    logic       is_idl, is_stp, fcrc_bad, fp_bad, len_bad, tok_bad;

    assign tok = stp_unpack(bus.rx_data);

    stp_fcrc_calc u_fcrc (
        .len_i  (tok.len),
        .fcrc_o (fcrc_calc),
        .fp_o   (fp_calc)
    );

    assign is_idl   = (bus.rx_data == 32'h0);
    assign is_stp   = (bus.rx_data[3:0] == STP_MARKER);
    assign fcrc_bad = (tok.fcrc != fcrc_calc);
    assign fp_bad   = (tok.fp != fp_calc);
    assign len_bad  = (tok.len < MIN_L) || (tok.len > MAX_L);
    assign tok_bad  = fcrc_bad || fp_bad || len_bad;

    rx_state_e        state_q;
    logic [10:0]      remaining_q;
    logic [11:0]      seq_q;
    logic             sop_pend_q;
    logic [31:0]      out_data_q;
    logic             out_valid_q, out_sop_q, out_eop_q, out_abort_q;
    logic [11:0]      out_seq_q;
    logic             err_fcrc_q, err_fp_q, err_len_q, err_unexp_q;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;

    // Saturate instead of wrapping so a long-running link never reports a small count.
    assign good_cnt_d = (&good_cnt_q) ? good_cnt_q : good_cnt_q + CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every read in
    // this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            seq_q       <= '0;
            sop_pend_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_seq_q   <= '0;
            out_abort_q <= 1'b0;
            err_fcrc_q  <= 1'b0;
            err_fp_q    <= 1'b0;
            err_len_q   <= 1'b0;
            err_unexp_q <= 1'b0;
            good_cnt_q  <= '0;
        end else begin
            // All outputs are single-beat responses; they drop to zero unless set below.
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_seq_q   <= '0;
            out_abort_q <= 1'b0;
            err_fcrc_q  <= 1'b0;
            err_fp_q    <= 1'b0;
            err_len_q   <= 1'b0;
            err_unexp_q <= 1'b0;

            if (bus.rx_flush) begin
                out_abort_q <= (state_q == ST_PAYLOAD);
                state_q     <= ST_IDLE;
                remaining_q <= '0;
            end else if (bus.rx_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (is_stp) begin
                            err_fcrc_q <= fcrc_bad;
                            err_fp_q   <= fp_bad;
                            err_len_q  <= len_bad;
                            if (!tok_bad) begin
                                seq_q       <= tok.seq;
                                remaining_q <= tok.len - 11'd1;
                                sop_pend_q  <= 1'b1;
                                state_q     <= ST_PAYLOAD;
                            end
                        end else if (!is_idl) begin
                            err_unexp_q <= 1'b1;
                        end
                    end
                    ST_PAYLOAD: begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= bus.rx_data;
                        out_seq_q   <= seq_q;
                        out_sop_q   <= sop_pend_q;
                        sop_pend_q  <= 1'b0;
                        remaining_q <= remaining_q - 11'd1;
                        if (remaining_q == 11'd1) begin
                            out_eop_q  <= 1'b1;
                            good_cnt_q <= good_cnt_d;
                            state_q    <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.out_seq   = out_seq_q;
    assign bus.out_abort = out_abort_q;
    assign bus.err_fcrc  = err_fcrc_q;
    assign bus.err_fp    = err_fp_q;
    assign bus.err_len   = err_len_q;
    assign bus.err_unexp = err_unexp_q;
    assign bus.good_cnt  = good_cnt_q;

endmodule
